laser_burst_tx: RTL and testbench

//  Transmit side of the laser/photodiode link. Converts flex-sensor squeezes (flex_l, flex_r)

---
 rtl/laser_burst_tx_pkg.sv | 20 ++
 rtl/laser_burst_tx_if.sv | 25 ++
 rtl/laser_burst_tx_chan_fsm.sv | 127 ++++++++++++
 rtl/laser_burst_tx.sv | 67 ++++++
 tb/tb_laser_burst_tx.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_burst_tx_pkg.sv
// Shared types and constants for the laser burst transmitter.
// The hand ID codes live here so the photo receive path can import the same values.
package laser_pkg;

  // Per-channel frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_COOL
  } chan_state_t;

  // Width of the hand ID code sent after the start bit
  localparam int CODE_W = 4;

  // Default hand IDs, sent MSB first
  localparam logic [CODE_W-1:0] CODE_L_DEFAULT = 4'b1010;
  localparam logic [CODE_W-1:0] CODE_R_DEFAULT = 4'b1100;

endpackage

// File: rtl/laser_burst_tx_if.sv
// Glove-side bundle for the laser burst transmitter: flex sensor inputs,
// laser drive outputs, per-channel busy flags and the shared shot counter.
interface laser_burst_tx_if;

  logic       flex_l;
  logic       flex_r;
  logic       laser_l;
  logic       laser_r;
  logic       busy_l;
  logic       busy_r;
  logic [7:0] shot_count;

  // Master side drives the flex sensors and watches the lasers
  modport master (
    output flex_l, flex_r,
    input  laser_l, laser_r, busy_l, busy_r, shot_count
  );

  // Slave side is the transmitter itself
  modport slave (
    input  flex_l, flex_r,
    output laser_l, laser_r, busy_l, busy_r, shot_count
  );

endinterface

// File: rtl/laser_burst_tx_chan_fsm.sv
// One laser channel: flex synchroniser, rising-edge trigger, frame sequencer
// and bit/cooldown timer. A frame is a start bit followed by CODE, MSB first,
// then a cooldown with the laser off.
// Optional build macro LASER_AUTOFIRE_EN re-fires straight from cooldown
// while the flex sensor is still held.
module laser_chan_fsm
  import laser_pkg::*;
#(
  parameter int                BIT_CYCLES      = 50000,
  parameter int                COOLDOWN_CYCLES = 12500000,
  parameter logic [CODE_W-1:0] CODE            = CODE_L_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic flex,
  output logic laser,
  output logic busy,
  output logic start
);

  localparam int TIMER_MAX = (BIT_CYCLES > COOLDOWN_CYCLES) ? BIT_CYCLES : COOLDOWN_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX);
  localparam int IW        = $clog2(CODE_W);

  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] COOL_LAST = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MSB   = IW'(CODE_W - 1);

  chan_state_t   state;
  logic [TW-1:0] timer;
  logic [IW-1:0] idx;
  logic          flex_meta;
  logic          flex_sync;
  logic          flex_prev;
  logic          trig;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flex_meta <= 1'b0;
      flex_sync <= 1'b0;
      flex_prev <= 1'b0;
    end else begin
      flex_meta <= flex;
      flex_sync <= flex_meta;
      flex_prev <= flex_sync;
    end
  end

  assign trig = flex_sync & ~flex_prev;

  // Frame sequencer; laser/busy/start are registered from the next state so the pins never glitch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      timer <= '0;
      idx   <= '0;
      laser <= 1'b0;
      busy  <= 1'b0;
      start <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trig) begin
            state <= ST_START;
            timer <= '0;
            laser <= 1'b1;
            busy  <= 1'b1;
            start <= 1'b1;
          end
        end
        ST_START: begin
          if (timer == BIT_LAST) begin
            state <= ST_DATA;
            timer <= '0;
            idx   <= IDX_MSB;
            laser <= CODE[IDX_MSB];
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (idx == '0) begin
              state <= ST_COOL;
              laser <= 1'b0;
            end else begin
              idx   <= idx - IW'(1);
              laser <= CODE[idx - IW'(1)];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_COOL: begin
          if (timer == COOL_LAST) begin
            timer <= '0;
`ifdef LASER_AUTOFIRE_EN
            if (flex_sync) begin
              state <= ST_START;
              laser <= 1'b1;
              start <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
`else
            state <= ST_IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
          laser <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/laser_burst_tx.sv
// Laser burst transmitter: turns left/right flex squeezes into coded
// on-off-keyed laser frames so the photodiode array can tell the hands apart.
// Two independent channels share one 8-bit frame counter that wraps freely.
// Optional build macro LASER_AUTOFIRE_EN makes a held squeeze fire repeatedly.
module laser_burst_tx
  import laser_pkg::*;
#(
  parameter int                BIT_CYCLES      = 50000,
  parameter int                COOLDOWN_CYCLES = 12500000,
  parameter logic [CODE_W-1:0] CODE_L          = CODE_L_DEFAULT,
  parameter logic [CODE_W-1:0] CODE_R          = CODE_R_DEFAULT
) (
  input logic             clock,
  input logic             reset,
  laser_burst_tx_if.slave bus
);

  logic       laser_l;
  logic       laser_r;
  logic       busy_l;
  logic       busy_r;
  logic       start_l;
  logic       start_r;
  logic [7:0] shot_q;

  laser_chan_fsm #(
    .BIT_CYCLES      (BIT_CYCLES),
    .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
    .CODE            (CODE_L)
  ) u_chan_l (
    .clock (clock),
    .reset (reset),
    .flex  (bus.flex_l),
    .laser (laser_l),
    .busy  (busy_l),
    .start (start_l)
  );

  laser_chan_fsm #(
    .BIT_CYCLES      (BIT_CYCLES),
    .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
    .CODE            (CODE_R)
  ) u_chan_r (
    .clock (clock),
    .reset (reset),
    .flex  (bus.flex_r),
    .laser (laser_r),
    .busy  (busy_r),
    .start (start_r)
  );

  // Count frames from both channels; two starts in one cycle add two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shot_q <= '0;
    end else begin
      shot_q <= shot_q + 8'(start_l) + 8'(start_r);
    end
  end

  assign bus.laser_l    = laser_l;
  assign bus.laser_r    = laser_r;
  assign bus.busy_l     = busy_l;
  assign bus.busy_r     = busy_r;
  assign bus.shot_count = shot_q;

endmodule

// File: tb/tb_laser_burst_tx.sv
// Self-checking bench for laser_burst_tx with short bit and cooldown times.
// Expected laser patterns are queued when a flex pulse is driven and popped
// one per clock as the frame comes out.
module tb_laser_burst_tx;

  localparam int BIT_CYC   = 4;
  localparam int COOL_CYC  = 10;
  localparam int FRAME_CYC = 5 * BIT_CYC;
  localparam int TOTAL_CYC = FRAME_CYC + COOL_CYC;

  localparam logic [19:0] PAT_L = 20'b1111_1111_0000_1111_0000;
  localparam logic [19:0] PAT_R = 20'b1111_1111_1111_0000_0000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] exp_shots = '0;
  bit         exp_l_q[$];
  bit         exp_r_q[$];

  laser_burst_tx_if bus();

  laser_burst_tx #(
    .BIT_CYCLES      (BIT_CYC),
    .COOLDOWN_CYCLES (COOL_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Queue one full frame (pattern plus cooldown zeros) for a channel
  function automatic void push_frame(input bit right, input logic [19:0] pat);
    for (int i = 19; i >= 0; i--) begin
      if (right) exp_r_q.push_back(pat[i]);
      else       exp_l_q.push_back(pat[i]);
    end
    for (int i = 0; i < COOL_CYC; i++) begin
      if (right) exp_r_q.push_back(1'b0);
      else       exp_l_q.push_back(1'b0);
    end
  endfunction

  function automatic void push_zeros(input bit right, input int n);
    for (int i = 0; i < n; i++) begin
      if (right) exp_r_q.push_back(1'b0);
      else       exp_l_q.push_back(1'b0);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.flex_l = 1'($urandom_range(0, 1));
      bus.flex_r = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if ({bus.laser_l, bus.laser_r, bus.busy_l, bus.busy_r} !== 4'b0000 || bus.shot_count !== 8'd0) begin
        n_fails++;
        $display("[TB] FAIL reset_hold cycle %0d: got laser/busy=%b shot=%0d, want 0000 shot=0",
                 i, {bus.laser_l, bus.laser_r, bus.busy_l, bus.busy_r}, bus.shot_count);
      end
    end
    bus.flex_l = 1'b0;
    bus.flex_r = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    repeat (4) tick();
    n_checks++;
    if ({bus.laser_l, bus.laser_r, bus.busy_l, bus.busy_r} !== 4'b0000 || bus.shot_count !== 8'd0) begin
      n_fails++;
      $display("[TB] FAIL reset_release: got laser/busy=%b shot=%0d, want 0000 shot=0",
               {bus.laser_l, bus.laser_r, bus.busy_l, bus.busy_r}, bus.shot_count);
    end
  endtask

  task automatic test_single_shot();
    bit el, er;
    push_frame(1'b0, PAT_L);
    push_zeros(1'b1, TOTAL_CYC);
    bus.flex_l = 1'b1;
    tick();
    bus.flex_l = 1'b0;
    tick();
    tick();
    exp_shots = exp_shots + 8'd1;
    for (int i = 0; i < TOTAL_CYC; i++) begin
      el = exp_l_q.pop_front();
      er = exp_r_q.pop_front();
      n_checks++;
      if (bus.laser_l !== el || bus.laser_r !== er || bus.busy_l !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL single_shot cycle %0d: got laser_l=%b laser_r=%b busy_l=%b, want %b %b 1",
                 i, bus.laser_l, bus.laser_r, bus.busy_l, el, er);
      end
      tick();
    end
    n_checks++;
    if (bus.busy_l !== 1'b0 || bus.shot_count !== exp_shots) begin
      n_fails++;
      $display("[TB] FAIL single_shot_end: got busy_l=%b shot=%0d, want 0 shot=%0d",
               bus.busy_l, bus.shot_count, exp_shots);
    end
    repeat (3) tick();
  endtask

  task automatic test_retrigger_drop();
    bit el;
    push_frame(1'b0, PAT_L);
    push_zeros(1'b0, 10);
    bus.flex_l = 1'b1;
    tick();
    bus.flex_l = 1'b0;
    tick();
    tick();
    exp_shots = exp_shots + 8'd1;
    for (int i = 0; i < TOTAL_CYC + 10; i++) begin
      el = exp_l_q.pop_front();
      n_checks++;
      if (bus.laser_l !== el) begin
        n_fails++;
        $display("[TB] FAIL retrigger cycle %0d: got laser_l=%b, want %b", i, bus.laser_l, el);
      end
      bus.flex_l = (i == 8 || i == 22) ? 1'b1 : 1'b0;
      tick();
    end
    n_checks++;
    if (bus.busy_l !== 1'b0 || bus.shot_count !== exp_shots) begin
      n_fails++;
      $display("[TB] FAIL retrigger_end: got busy_l=%b shot=%0d, want 0 shot=%0d",
               bus.busy_l, bus.shot_count, exp_shots);
    end
    repeat (3) tick();
  endtask

  task automatic test_simultaneous();
    bit el, er;
    push_frame(1'b0, PAT_L);
    push_frame(1'b1, PAT_R);
    bus.flex_l = 1'b1;
    bus.flex_r = 1'b1;
    tick();
    bus.flex_l = 1'b0;
    bus.flex_r = 1'b0;
    tick();
    tick();
    exp_shots = exp_shots + 8'd2;
    for (int i = 0; i < TOTAL_CYC; i++) begin
      el = exp_l_q.pop_front();
      er = exp_r_q.pop_front();
      n_checks++;
      if (bus.laser_l !== el || bus.laser_r !== er || bus.busy_l !== 1'b1 || bus.busy_r !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL simultaneous cycle %0d: got laser_l=%b laser_r=%b busy=%b%b, want %b %b 11",
                 i, bus.laser_l, bus.laser_r, bus.busy_l, bus.busy_r, el, er);
      end
      tick();
    end
    n_checks++;
    if (bus.busy_l !== 1'b0 || bus.busy_r !== 1'b0 || bus.shot_count !== exp_shots) begin
      n_fails++;
      $display("[TB] FAIL simultaneous_end: got busy=%b%b shot=%0d, want 00 shot=%0d",
               bus.busy_l, bus.busy_r, bus.shot_count, exp_shots);
    end
    repeat (3) tick();
  endtask

  task automatic test_held_flex();
    bit el;
    push_frame(1'b0, PAT_L);
`ifdef LASER_AUTOFIRE_EN
    push_frame(1'b0, PAT_L);
`else
    push_zeros(1'b0, TOTAL_CYC);
`endif
    bus.flex_l = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 2 * TOTAL_CYC; i++) begin
      el = exp_l_q.pop_front();
      n_checks++;
      if (bus.laser_l !== el) begin
        n_fails++;
        $display("[TB] FAIL held_flex cycle %0d: got laser_l=%b, want %b", i, bus.laser_l, el);
      end
      tick();
    end
    bus.flex_l = 1'b0;
`ifdef LASER_AUTOFIRE_EN
    exp_shots = exp_shots + 8'd3;
    repeat (45) tick();
`else
    exp_shots = exp_shots + 8'd1;
    repeat (3) tick();
`endif
    n_checks++;
    if (bus.busy_l !== 1'b0 || bus.shot_count !== exp_shots) begin
      n_fails++;
      $display("[TB] FAIL held_flex_end: got busy_l=%b shot=%0d, want 0 shot=%0d",
               bus.busy_l, bus.shot_count, exp_shots);
    end
  endtask

  task automatic test_wrap();
    while (exp_shots != 8'd255) begin
      if ((8'd255 - exp_shots) >= 8'd2) begin
        bus.flex_r = 1'b1;
        exp_shots = exp_shots + 8'd2;
      end else begin
        exp_shots = exp_shots + 8'd1;
      end
      bus.flex_l = 1'b1;
      tick();
      bus.flex_l = 1'b0;
      bus.flex_r = 1'b0;
      repeat (TOTAL_CYC + 5) tick();
    end
    n_checks++;
    if (bus.shot_count !== 8'd255) begin
      n_fails++;
      $display("[TB] FAIL wrap_preload: got shot=%0d, want 255", bus.shot_count);
    end
    bus.flex_l = 1'b1;
    tick();
    bus.flex_l = 1'b0;
    exp_shots = exp_shots + 8'd1;
    repeat (TOTAL_CYC + 5) tick();
    n_checks++;
    if (bus.shot_count !== 8'd0 || exp_shots !== 8'd0) begin
      n_fails++;
      $display("[TB] FAIL wrap_rollover: got shot=%0d, want 0", bus.shot_count);
    end
  endtask

  task automatic test_abort();
    bus.flex_l = 1'b1;
    tick();
    bus.flex_l = 1'b0;
    tick();
    tick();
    repeat (6) tick();
    n_checks++;
    if (bus.laser_l !== PAT_L[13] || bus.busy_l !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL abort_pre: got laser_l=%b busy_l=%b, want %b 1", bus.laser_l, bus.busy_l, PAT_L[13]);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.laser_l !== 1'b0 || bus.busy_l !== 1'b0 || bus.shot_count !== 8'd0) begin
      n_fails++;
      $display("[TB] FAIL abort_async: got laser_l=%b busy_l=%b shot=%0d, want 0 0 0",
               bus.laser_l, bus.busy_l, bus.shot_count);
    end
    exp_shots = '0;
    tick();
    tick();
    reset = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (bus.laser_l !== 1'b0 || bus.busy_l !== 1'b0 || bus.shot_count !== exp_shots) begin
      n_fails++;
      $display("[TB] FAIL abort_after: got laser_l=%b busy_l=%b shot=%0d, want 0 0 %0d",
               bus.laser_l, bus.busy_l, bus.shot_count, exp_shots);
    end
  endtask

  initial begin
    bus.flex_l = 1'b0;
    bus.flex_r = 1'b0;
    test_reset();
    test_single_shot();
    test_retrigger_drop();
    test_simultaneous();
    test_held_flex();
    test_wrap();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
